// File: rtl/instr_rom_responder.sv
// -----------------------------------------------------------------------------
// instr_rom_responder
//
// Purpose:
//   Responder side of the syn/ack/last sequential instruction-stream
//   handshake. A loadable word memory holds the program image. While the
//   initiator holds r_i_syn high, words are streamed in ascending address
//   order, one per r_o_ack strobe, with WAIT_CYCLES idle cycles before each
//   word. The word at LAST_ADDR is flagged with r_o_last. After that word the
//   block parks until syn is released, and the next request restarts at 0.
//
// Ports:
//   r_clk      in   1       clock, rising edge
//   r_rst      in   1       synchronous active-low reset
//   r_i_syn    in   1       stream request (level)
//   r_i_we     in   1       memory load write enable
//   r_i_waddr  in   DEPTH   memory load address
//   r_i_wdata  in   IWIDTH  memory load data
//   r_o_instr  out  IWIDTH  delivered word, valid with r_o_ack
//   r_o_last   out  1       delivered word is at LAST_ADDR
//   r_o_ack    out  1       one-cycle strobe per delivered word
// -----------------------------------------------------------------------------
module instr_rom_responder #(
    parameter int IWIDTH      = 32,
    parameter int DEPTH       = 7,
    parameter int LAST_ADDR   = (1 << DEPTH) - 1,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              r_clk,
    input  logic              r_rst,
    input  logic              r_i_syn,
    input  logic              r_i_we,
    input  logic [DEPTH-1:0]  r_i_waddr,
    input  logic [IWIDTH-1:0] r_i_wdata,
    output logic [IWIDTH-1:0] r_o_instr,
    output logic              r_o_last,
    output logic              r_o_ack
);

    // Counter must hold WAIT_CYCLES; keep at least one bit when it is zero.
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    localparam logic [CW-1:0]    WAIT_P = CW'(WAIT_CYCLES);
    localparam logic [DEPTH-1:0] LAST_P = DEPTH'(LAST_ADDR);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DEPTH-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IWIDTH-1:0]   instr_q, instr_d;
    logic                last_q, last_d;
    logic                ack_q, ack_d;

    logic [IWIDTH-1:0]   mem_q [0:(1 << DEPTH) - 1];
    logic [IWIDTH-1:0]   rd_data_s;

    // Program image storage; loadable in any state and never reset.
    always_ff @(posedge r_clk) begin
        if (r_i_we) begin
            mem_q[r_i_waddr] <= r_i_wdata;
        end
    end

    // Combinational read: the output register samples the pre-write word,
    // so a same-edge write to the issued address returns the old contents.
    assign rd_data_s = mem_q[ptr_q];

    // Next-state and registered-output decode for the stream FSM.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        instr_d = {IWIDTH{1'b0}};
        last_d  = 1'b0;
        ack_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (r_i_syn) begin
                    cnt_d   = WAIT_P;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_FETCH: begin
                if (!r_i_syn) begin
                    // ptr is kept so a later request resumes at the first
                    // word that was not yet acked.
                    state_d = ST_IDLE;
                end else if (cnt_q != {CW{1'b0}}) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    ack_d   = 1'b1;
                    instr_d = rd_data_s;
                    last_d  = (ptr_q == LAST_P);
                    if (ptr_q == LAST_P) begin
                        ptr_d   = {DEPTH{1'b0}};
                        state_d = ST_DONE;
                    end else begin
                        ptr_d = ptr_q + DEPTH'(1);
                        cnt_d = WAIT_P;
                    end
                end
            end

            ST_DONE: begin
                if (!r_i_syn) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                ptr_d   = {DEPTH{1'b0}};
                cnt_d   = {CW{1'b0}};
            end
        endcase
    end

    // State, pointer, counter and output registers with synchronous reset.
    always_ff @(posedge r_clk) begin
        if (!r_rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= {DEPTH{1'b0}};
            cnt_q   <= {CW{1'b0}};
            instr_q <= {IWIDTH{1'b0}};
            last_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
            last_q  <= last_d;
            ack_q   <= ack_d;
        end
    end

    assign r_o_instr = instr_q;
    assign r_o_last  = last_q;
    assign r_o_ack   = ack_q;

endmodule

// File: tb/tb_instr_rom_responder.sv
// -----------------------------------------------------------------------------
// tb_instr_rom_responder
//
// Directed bench for instr_rom_responder. Two instances share all inputs:
// u_w0 (WAIT_CYCLES=0) and u_w2 (WAIT_CYCLES=2), both with LAST_ADDR=2.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the
// same point, so each step() observes the result of exactly one edge.
// -----------------------------------------------------------------------------
module tb_instr_rom_responder;

    localparam int IW = 32;
    localparam int DP = 7;

    logic          r_clk;
    logic          r_rst;
    logic          r_i_syn;
    logic          r_i_we;
    logic [DP-1:0] r_i_waddr;
    logic [IW-1:0] r_i_wdata;

    logic [IW-1:0] instr0, instr2;
    logic          last0, last2;
    logic          ack0, ack2;

    int vectors;
    int miscompares;

    instr_rom_responder #(
        .IWIDTH(IW), .DEPTH(DP), .LAST_ADDR(2), .WAIT_CYCLES(0)
    ) u_w0 (
        .r_clk(r_clk), .r_rst(r_rst), .r_i_syn(r_i_syn), .r_i_we(r_i_we),
        .r_i_waddr(r_i_waddr), .r_i_wdata(r_i_wdata),
        .r_o_instr(instr0), .r_o_last(last0), .r_o_ack(ack0)
    );

    instr_rom_responder #(
        .IWIDTH(IW), .DEPTH(DP), .LAST_ADDR(2), .WAIT_CYCLES(2)
    ) u_w2 (
        .r_clk(r_clk), .r_rst(r_rst), .r_i_syn(r_i_syn), .r_i_we(r_i_we),
        .r_i_waddr(r_i_waddr), .r_i_wdata(r_i_wdata),
        .r_o_instr(instr2), .r_o_last(last2), .r_o_ack(ack2)
    );

    initial r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    task automatic step();
        @(posedge r_clk);
        #1;
    endtask

    task automatic do_reset();
        r_rst   = 1'b0;
        r_i_syn = 1'b0;
        step();
        r_rst = 1'b1;
    endtask

    task automatic load(input logic [DP-1:0] a, input logic [IW-1:0] d);
        r_i_we    = 1'b1;
        r_i_waddr = a;
        r_i_wdata = d;
        step();
        r_i_we = 1'b0;
    endtask

    // Reset state of both instances.
    task automatic test_reset();
        logic [IW+1:0] exp_v;
        exp_v = {(IW + 2){1'b0}};
        do_reset();
        vectors++;
        if ({ack0, last0, instr0} !== exp_v) begin
            miscompares++;
            $display("FAIL reset_w0: got ack=%0b last=%0b instr=%08h, want all 0",
                     ack0, last0, instr0);
        end
        vectors++;
        if ({ack2, last2, instr2} !== exp_v) begin
            miscompares++;
            $display("FAIL reset_w2: got ack=%0b last=%0b instr=%08h, want all 0",
                     ack2, last2, instr2);
        end
    endtask

    // Back-to-back stream with WAIT_CYCLES=0, then hold syn high in DONE.
    task automatic test_stream();
        logic [IW-1:0] img [3];
        logic [IW+1:0] exp_v;
        img[0] = 32'h0000_0011;
        img[1] = 32'h0000_0022;
        img[2] = 32'h0000_0033;
        do_reset();
        r_i_syn = 1'b1;
        step();
        for (int k = 0; k < 7; k++) begin
            step();
            if (k < 3) exp_v = {1'b1, (k == 2), img[k]};
            else       exp_v = {(IW + 2){1'b0}};
            vectors++;
            if ({ack0, last0, instr0} !== exp_v) begin
                miscompares++;
                $display("FAIL stream_c%0d: got ack=%0b last=%0b instr=%08h, want ack=%0b last=%0b instr=%08h",
                         k, ack0, last0, instr0, exp_v[IW+1], exp_v[IW], exp_v[IW-1:0]);
            end
        end
    endtask

    // WAIT_CYCLES=2: acks three cycles apart, first three edges after syn.
    task automatic test_wait();
        logic [IW-1:0] img [3];
        logic [IW+1:0] exp_v;
        img[0] = 32'h0000_0011;
        img[1] = 32'h0000_0022;
        img[2] = 32'h0000_0033;
        do_reset();
        r_i_syn = 1'b1;
        step();
        for (int c = 1; c <= 12; c++) begin
            step();
            if (c % 3 == 0 && c <= 9) exp_v = {1'b1, (c == 9), img[c / 3 - 1]};
            else                      exp_v = {(IW + 2){1'b0}};
            vectors++;
            if ({ack2, last2, instr2} !== exp_v) begin
                miscompares++;
                $display("FAIL wait_c%0d: got ack=%0b last=%0b instr=%08h, want ack=%0b last=%0b instr=%08h",
                         c, ack2, last2, instr2, exp_v[IW+1], exp_v[IW], exp_v[IW-1:0]);
            end
        end
    endtask

    // syn drop mid-stream resumes at the next word; after the last word a
    // one-cycle release restarts the stream at address 0.
    task automatic test_resume_restart();
        logic [IW+1:0] exp_v [10];
        logic          syn_v [10];
        do_reset();
        r_i_syn = 1'b1;
        step();
        // syn value applied before each edge, and expected outputs after it
        syn_v[0] = 1'b1; exp_v[0] = {2'b10, 32'h0000_0011};
        syn_v[1] = 1'b1; exp_v[1] = {2'b10, 32'h0000_0022};
        syn_v[2] = 1'b0; exp_v[2] = {(IW + 2){1'b0}};
        syn_v[3] = 1'b0; exp_v[3] = {(IW + 2){1'b0}};
        syn_v[4] = 1'b0; exp_v[4] = {(IW + 2){1'b0}};
        syn_v[5] = 1'b1; exp_v[5] = {(IW + 2){1'b0}};
        syn_v[6] = 1'b1; exp_v[6] = {2'b11, 32'h0000_0033};
        syn_v[7] = 1'b0; exp_v[7] = {(IW + 2){1'b0}};
        syn_v[8] = 1'b1; exp_v[8] = {(IW + 2){1'b0}};
        syn_v[9] = 1'b1; exp_v[9] = {2'b10, 32'h0000_0011};
        for (int k = 0; k < 10; k++) begin
            r_i_syn = syn_v[k];
            step();
            vectors++;
            if ({ack0, last0, instr0} !== exp_v[k]) begin
                miscompares++;
                $display("FAIL resume_c%0d: got ack=%0b last=%0b instr=%08h, want ack=%0b last=%0b instr=%08h",
                         k, ack0, last0, instr0, exp_v[k][IW+1], exp_v[k][IW], exp_v[k][IW-1:0]);
            end
        end
    endtask

    // Reset in FETCH with ptr=1 aborts the stream; memory survives.
    task automatic test_reset_mid();
        logic [IW+1:0] exp_v [4];
        do_reset();
        r_i_syn = 1'b1;
        step();
        step();
        vectors++;
        if ({ack0, instr0} !== {1'b1, 32'h0000_0011}) begin
            miscompares++;
            $display("FAIL rstmid_pre: got ack=%0b instr=%08h, want ack=1 instr=00000011",
                     ack0, instr0);
        end
        r_rst = 1'b0;
        step();
        r_rst = 1'b1;
        exp_v[0] = {(IW + 2){1'b0}};
        exp_v[1] = {(IW + 2){1'b0}};
        exp_v[2] = {2'b10, 32'h0000_0011};
        exp_v[3] = {2'b10, 32'h0000_0022};
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step();
            vectors++;
            if ({ack0, last0, instr0} !== exp_v[k]) begin
                miscompares++;
                $display("FAIL rstmid_c%0d: got ack=%0b last=%0b instr=%08h, want ack=%0b last=%0b instr=%08h",
                         k, ack0, last0, instr0, exp_v[k][IW+1], exp_v[k][IW], exp_v[k][IW-1:0]);
            end
        end
    endtask

    // Write to the address being issued on the same edge returns old data.
    task automatic test_rbw();
        do_reset();
        r_i_syn = 1'b1;
        step();
        step();
        r_i_we    = 1'b1;
        r_i_waddr = 7'd1;
        r_i_wdata = 32'h0000_0099;
        step();
        r_i_we = 1'b0;
        vectors++;
        if ({ack0, last0, instr0} !== {2'b10, 32'h0000_0022}) begin
            miscompares++;
            $display("FAIL rbw_old: got ack=%0b last=%0b instr=%08h, want ack=1 last=0 instr=00000022",
                     ack0, last0, instr0);
        end
        step();
        r_i_syn = 1'b0;
        step();
        r_i_syn = 1'b1;
        step();
        step();
        step();
        vectors++;
        if ({ack0, last0, instr0} !== {2'b10, 32'h0000_0099}) begin
            miscompares++;
            $display("FAIL rbw_new: got ack=%0b last=%0b instr=%08h, want ack=1 last=0 instr=00000099",
                     ack0, last0, instr0);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        r_rst       = 1'b0;
        r_i_syn     = 1'b0;
        r_i_we      = 1'b0;
        r_i_waddr   = {DP{1'b0}};
        r_i_wdata   = {IW{1'b0}};
        #1;
        test_reset();
        load(7'd0, 32'h0000_0011);
        load(7'd1, 32'h0000_0022);
        load(7'd2, 32'h0000_0033);
        test_stream();
        test_wait();
        test_resume_restart();
        test_reset_mid();
        test_rbw();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
